// File: rtl/precision_pkg.sv
// Float-format constants and enumerations shared by the power-of-two scaling blocks.
package precision_pkg;

    localparam int HALF_EXP_BITS    = 5;
    localparam int HALF_MANT_BITS   = 10;
    localparam int HALF_BIAS        = 15;
    localparam int SINGLE_EXP_BITS  = 8;
    localparam int SINGLE_MANT_BITS = 23;
    localparam int SINGLE_BIAS      = 127;

    // Signed working exponent: wide enough for any field value plus a 10-bit scale.
    localparam int INT_EXP_BITS     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4
    } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies an IEEE-754 word as zero, denormal, normal, infinity or NaN.
module fp_classify
    import precision_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int EXP_BITS  = HALF_EXP_BITS,
    parameter int MANT_BITS = HALF_MANT_BITS
) (
    input  logic [BITS-1:0] a,
    output fp_class_t       fp_class
);

    logic [EXP_BITS-1:0]  exp_s;
    logic [MANT_BITS-1:0] mant_s;
    logic                 sign_unused_s;

    assign exp_s         = a[MANT_BITS +: EXP_BITS];
    assign mant_s        = a[MANT_BITS-1:0];
    assign sign_unused_s = a[BITS-1];

    // Decode the exponent/mantissa fields into a float class.
    always_comb begin
        fp_class = NORMAL;
        if (exp_s == {EXP_BITS{1'b0}}) begin
            if (mant_s == {MANT_BITS{1'b0}}) begin
                fp_class = ZERO;
            end else begin
                fp_class = DENORM;
            end
        end else if (exp_s == {EXP_BITS{1'b1}}) begin
            if (mant_s == {MANT_BITS{1'b0}}) begin
                fp_class = INF;
            end else begin
                fp_class = NAN;
            end
        end else begin
            fp_class = NORMAL;
        end
    end

endmodule

// File: rtl/base_2_apply_exponent.sv
// Scales an IEEE-754 operand by 2^e. Denormal inputs are normalised one bit per
// cycle and underflowing results are denormalised (truncated) one bit per cycle.
module base_2_apply_exponent
    import precision_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BITS-1:0]      a,
    input  logic signed [9:0]    e,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BITS-1:0]      c,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int EXP_BITS  = (PRECISION == "SINGLE") ? SINGLE_EXP_BITS  : HALF_EXP_BITS;
    localparam int MANT_BITS = (PRECISION == "SINGLE") ? SINGLE_MANT_BITS : HALF_MANT_BITS;
    localparam int BIAS      = (PRECISION == "SINGLE") ? SINGLE_BIAS      : HALF_BIAS;
    localparam int CNT_W     = $clog2(MANT_BITS + 2);
    localparam logic signed [INT_EXP_BITS-1:0] EXP_INF_S   = INT_EXP_BITS'(2 * BIAS + 1);
    localparam logic signed [INT_EXP_BITS-1:0] SHIFT_MAX_S = INT_EXP_BITS'(MANT_BITS + 1);
    localparam logic [CNT_W-1:0]               SHIFT_MAX   = CNT_W'(MANT_BITS + 1);

    fp_class_t                       cls_s;
    logic signed [INT_EXP_BITS-1:0]  exp_a_s;
    logic signed [INT_EXP_BITS-1:0]  exp_sum_s;
    logic                            cand_sign_s;
    logic signed [INT_EXP_BITS-1:0]  cand_exp_s;
    logic [MANT_BITS:0]              cand_mant_s;
    logic signed [INT_EXP_BITS-1:0]  shift_amt_s;
    state_t                          dec_state_s;
    logic [BITS-1:0]                 dec_c_s;
    logic [CNT_W-1:0]                dec_cnt_s;

    state_t                          state_r;
    logic [BITS-1:0]                 c_r;
    logic                            out_valid_r;
    logic                            in_ready_r;
    logic                            sign_r;
    logic signed [INT_EXP_BITS-1:0]  exp_r;
    logic [MANT_BITS:0]              mant_r;
    logic [CNT_W-1:0]                cnt_r;

    fp_classify #(
        .BITS      (BITS),
        .EXP_BITS  (EXP_BITS),
        .MANT_BITS (MANT_BITS)
    ) u_classify (
        .a        (a),
        .fp_class (cls_s)
    );

    // Scaled exponent of the incoming operand; a denormal counts as exponent 1.
    always_comb begin
        if (cls_s == DENORM) begin
            exp_a_s = 12'sd1;
        end else begin
            exp_a_s = $signed({{(INT_EXP_BITS-EXP_BITS){1'b0}}, a[MANT_BITS +: EXP_BITS]});
        end
        exp_sum_s = exp_a_s + $signed({{(INT_EXP_BITS-10){e[9]}}, e});
    end

    // Candidate for the range decision: fresh operand in IDLE, next normalisation step in NORM.
    always_comb begin
        if (state_r == NORM) begin
            cand_sign_s = sign_r;
            cand_exp_s  = exp_r - 12'sd1;
            cand_mant_s = {mant_r[MANT_BITS-1:0], 1'b0};
        end else begin
            cand_sign_s = a[BITS-1];
            cand_exp_s  = exp_sum_s;
            cand_mant_s = {1'b1, a[MANT_BITS-1:0]};
        end
    end

    // Range decision: overflow to infinity, normal result, or underflow into SHIFT.
    always_comb begin
        shift_amt_s = 12'sd1 - cand_exp_s;
        dec_state_s = DONE;
        dec_cnt_s   = {CNT_W{1'b0}};
        dec_c_s     = {cand_sign_s, cand_exp_s[EXP_BITS-1:0], cand_mant_s[MANT_BITS-1:0]};
        if (cand_exp_s >= EXP_INF_S) begin
            dec_c_s = {cand_sign_s, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
        end else if (cand_exp_s >= 12'sd1) begin
            dec_state_s = DONE;
        end else begin
            dec_state_s = SHIFT;
            // Shifting past every mantissa bit only ever yields zero.
            if (shift_amt_s > SHIFT_MAX_S) begin
                dec_cnt_s = SHIFT_MAX;
            end else begin
                dec_cnt_s = shift_amt_s[CNT_W-1:0];
            end
        end
    end

    // Control FSM with registered result, handshake flags and working operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            c_r         <= {BITS{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            sign_r      <= 1'b0;
            exp_r       <= 12'sd0;
            mant_r      <= {(MANT_BITS+1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
                        sign_r     <= a[BITS-1];
                        case (cls_s)
                            DENORM: begin
                                state_r <= NORM;
                                exp_r   <= exp_sum_s;
                                mant_r  <= {1'b0, a[MANT_BITS-1:0]};
                            end
                            NORMAL: begin
                                state_r <= dec_state_s;
                                mant_r  <= cand_mant_s;
                                cnt_r   <= dec_cnt_s;
                                if (dec_state_s == DONE) begin
                                    c_r         <= dec_c_s;
                                    out_valid_r <= 1'b1;
                                end
                            end
                            default: begin
                                state_r     <= DONE;
                                c_r         <= a;
                                out_valid_r <= 1'b1;
                            end
                        endcase
                    end
                end
                NORM: begin
                    if (cand_mant_s[MANT_BITS]) begin
                        state_r <= dec_state_s;
                        mant_r  <= cand_mant_s;
                        cnt_r   <= dec_cnt_s;
                        if (dec_state_s == DONE) begin
                            c_r         <= dec_c_s;
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        exp_r  <= cand_exp_s;
                        mant_r <= cand_mant_s;
                    end
                end
                SHIFT: begin
                    mant_r <= {1'b0, mant_r[MANT_BITS:1]};
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= DONE;
                        c_r         <= {sign_r, {EXP_BITS{1'b0}}, mant_r[MANT_BITS:1]};
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign c         = c_r;
    assign out_valid = out_valid_r;

endmodule

// File: doc/base_2_apply_exponent.md
BASE_2_APPLY_EXPONENT -- requirements
Module: base_2_apply_exponent

Interface
REQ-001 Parameter BITS, default 16, SHALL set the float word width.
REQ-002 Parameter PRECISION, default "HALF", SHALL select the format: "HALF" (5-bit exponent, 10-bit mantissa) or "SINGLE" (8-bit exponent, 23-bit mantissa; BITS=32).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port a, input, BITS bits, SHALL carry the IEEE-754 operand, typically a significand with exponent field equal to bias.
REQ-006 Port e, input, 10 bits signed (two's complement), SHALL carry the power-of-two scale.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify a and e.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate that an operand can be accepted.
REQ-009 Port c, output, BITS bits, SHALL carry the result a*2^e.
REQ-010 Port out_valid, output, 1 bit, SHALL qualify c.
REQ-011 Port out_ready, input, 1 bit, SHALL accept c.

Function
REQ-012 The block SHALL accept an operand when in_valid && in_ready; in_ready SHALL equal (state==IDLE).
REQ-013 The FSM SHALL have the states IDLE, NORM, SHIFT, DONE.
- IDLE -> NORM on accept of a denormal operand.
- IDLE -> SHIFT when the computed biased exponent is <= 0.
- IDLE -> DONE otherwise.
REQ-014 Arithmetic SHALL use a 12-bit signed internal exponent: E = expA + e, where expA = 1 for a denormal operand before normalization.
REQ-015 Zero, infinity and NaN operands SHALL pass through unchanged; e is ignored; sign and NaN payload are preserved. Latency: accept to out_valid = 1 cycle.
REQ-016 Normal result (1 <= E <= 2^EXP_BITS-2): c SHALL be {signA, E, mantA}, and out_valid SHALL assert 1 cycle after accept.
REQ-017 Overflow (E >= 2^EXP_BITS-1): c SHALL be signed infinity; latency 1 cycle.
REQ-018 NORM SHALL left-shift the mantissa 1 bit per cycle and decrement E until the implicit-bit position is 1, then re-enter the normal/overflow/SHIFT decision.
REQ-019 SHIFT SHALL right-shift {1,mant} 1 bit per cycle, (1-E) times, then store the result with exponent field 0.
- Rounding is toward zero (truncate).
- If (1-E) > MANT_BITS+1, the shift count SHALL saturate at MANT_BITS+1, giving signed zero.
REQ-020 In DONE, c and out_valid SHALL hold stable until out_ready; on out_valid && out_ready the FSM SHALL return to IDLE.
- No operand is accepted in that same cycle.
- Maximum throughput is 1 result per 2 cycles.
REQ-021 The sign of c SHALL always equal the sign of a.

Reset
REQ-022 On reset_n low, asynchronously:
- state = IDLE
- c = 0
- out_valid = 0
- in_ready = 1 once state is IDLE
REQ-023 A reset asserted in NORM, SHIFT or DONE SHALL abort the operation; no result is produced for it.

Structure
REQ-024 Package precision_pkg SHALL hold:
- EXP_BITS, MANT_BITS and BIAS per precision
- the FSM state enum
- the float class enum (ZERO, DENORM, NORMAL, INF, NAN)
REQ-025 Operand classification SHALL be a sub-module fp_classify (input a, output class), shared with other precision blocks.

Verification
REQ-026 HALF, a=0x3E00 (1.5), e=3 -> c=0x4A00; out_valid 1 cycle after accept.
REQ-027 HALF, a=0x3C00, e=16 -> c=0x7C00 (+inf); a=0xBC00, e=16 -> c=0xFC00.
REQ-028 HALF, a=0x3C00, e=-15 -> c=0x0200 after 1 SHIFT cycle; a=0x3C00, e=-40 -> c=0x0000 after 11 SHIFT cycles.
REQ-029 HALF, a=0x0001, e=24 -> c=0x3C00 after 10 NORM cycles; a=0x7E00 (NaN), e=-5 -> c=0x7E00.
REQ-030 Backpressure, a=0x3E00, e=3, out_ready low 3 cycles -> c=0x4A00 stable, out_valid=1, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-031 Reset pulse in SHIFT of a=0x3C00, e=-40 -> out_valid=0, in_ready=1, c=0; the next operand is processed normally.
